axi4_lite_sim_memory: RTL and testbench
=======================================

// Module: axi4_lite_sim_memory
// PURPOSE
//  Simulation-only AXI4-Lite slave: 128 KiB word-addressed RAM plus two memory-mapped test devices.
//  Serves as the program/data memory of an AXI CPU core in the processor testbench.
//  The array is preloadable by $readmemh through the hierarchical name "memory".
//  Provides a console output at 0x1000_0000 and a pass flag at 0x2000_0000.
//  With AXI_TEST set, it inserts pseudo-random handshake stalls.
// PARAMETERS
//  AXI_TEST  0  1 = gate readies/responses with LFSR bits (stall injection); 0 = fastest timing
//  VERBOSE   0  1 = $display every read/write transaction (addr, data, strb)
// PORTS
//  clk              in   1   clock, all logic on posedge
//  resetn           in   1   synchronous, active-low reset
//  mem_axi_awvalid  in   1   write address valid
//  mem_axi_awready  out  1   write address ready
//  mem_axi_awaddr   in   32  write byte address
//  mem_axi_awprot   in   3   ignored
//  mem_axi_wvalid   in   1   write data valid
//  mem_axi_wready   out  1   write data ready
//  mem_axi_wdata    in   32  write data
//  mem_axi_wstrb    in   4   byte enables, bit i -> wdata[8i+7:8i]
//  mem_axi_bvalid   out  1   write response valid (response always OKAY, no bresp port)
//  mem_axi_bready   in   1   write response ready
//  mem_axi_arvalid  in   1   read address valid
//  mem_axi_arready  out  1   read address ready
//  mem_axi_araddr   in   32  read byte address
//  mem_axi_arprot   in   3   ignored
//  mem_axi_rvalid   out  1   read data valid
//  mem_axi_rready   in   1   read data ready
//  mem_axi_rdata    out  32  read data
//  tests_passed     out  1   sticky pass flag
//  console_valid    out  1   1-cycle pulse on a console write
//  console_data     out  8   console byte (wdata[7:0])
// BEHAVIOUR
//  - Storage: reg [31:0] memory [0:32767]. Word index = addr[16:2]. RAM region: addr < 32'h0002_0000.
//  - Reset (resetn=0 at posedge):
//    - awready, wready, arready, bvalid, rvalid, console_valid, tests_passed = 0; rdata = 0.
//    - Address/data latches cleared; LFSR = 16'hACE1.
//    - Memory contents are not cleared.
//  - LFSR: 16-bit Fibonacci, taps 16,14,13,11, advances every non-reset cycle.
//    - g[k] = AXI_TEST ? lfsr[k] : 1.
//  - Readies are combinational and are 0 while resetn = 0:
//    - awready = !aw_full & g[1]
//    - wready  = !w_full  & g[2]
//    - arready = !ar_full & !rvalid & g[0]
//  - Write channel:
//    - AW and W handshakes are independent, either order; each stores into its latch (aw_full / w_full set).
//    - Commit edge: first posedge with aw_full & w_full & !bvalid & g[4].
//      - Byte-masked RAM write, or device access.
//      - bvalid <= 1; both latches cleared.
//      - Latency: commit one edge after the later handshake.
//    - bvalid holds until bvalid & bready at a posedge, then clears.
//  - Write decode at commit:
//    - RAM region: update bytes whose wstrb bit is set.
//    - 32'h1000_0000: console_valid pulses 1 cycle, console_data = wdata[7:0], $write("%c").
//    - 32'h2000_0000: tests_passed <= 1 iff wdata == 123456789; it never clears except on reset.
//    - Any other address: write dropped, bvalid still returned, $display error message.
//  - Read channel:
//    - AR handshake latches araddr.
//    - Next posedge with g[3]: rdata <= memory[idx], or 32'hDEADBEEF outside the RAM region; rvalid <= 1; latch cleared.
//    - rvalid and rdata stay stable until rvalid & rready at a posedge.
//    - Only one read outstanding; arready stays 0 while a read is latched or rvalid = 1.
//  - Read and write channels run concurrently.
//    - Same-word read and write in the same edge: the read returns the old data.
//  - Reset mid-transaction: all latched and pending transactions are dropped, with no partial write.
//  - VERBOSE: $display("RD %08x %08x") or ("WR %08x %08x %x") at commit.
// TESTING
//  - Preload memory[4] = 32'h1234_5678; read addr 0x10 with AXI_TEST=0 -> rvalid one edge after the AR handshake, rdata = 32'h1234_5678.
//  - Write 0x0000_0020 with wdata 32'hAABB_CCDD, wstrb 4'b0101, over 32'h0 -> memory[8] = 32'h00BB_00DD; bvalid held until bready.
//  - W sent 3 cycles before AW -> a single commit; bvalid rises one edge after the AW handshake.
//  - Write 0x2000_0000 with data 123456789 -> tests_passed = 1.
//    - Data 5 -> tests_passed stays 0.
//    - Pulse resetn -> tests_passed = 0.
//  - Write 0x1000_0000 with data 0x41 -> console_valid 1 cycle, console_data = 8'h41.
//    - Read 0x0004_0000 -> rdata = 32'hDEADBEEF.
//  - AXI_TEST=1: 1000 random reads/writes against a scoreboard -> all data matches, no handshake dropped, rvalid/rdata stable while rready = 0.

Source files
------------

// File: rtl/axi4_lite_sim_memory.sv
// rtl/axi4_lite_sim_memory.sv - AXI4-Lite simulation memory with console and pass-flag devices
module axi4_lite_sim_memory #(
  parameter int AXI_TEST = 0,
  parameter int VERBOSE  = 0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_axi_awvalid,
  output logic        mem_axi_awready,
  input  logic [31:0] mem_axi_awaddr,
  input  logic [2:0]  mem_axi_awprot,
  input  logic        mem_axi_wvalid,
  output logic        mem_axi_wready,
  input  logic [31:0] mem_axi_wdata,
  input  logic [3:0]  mem_axi_wstrb,
  output logic        mem_axi_bvalid,
  input  logic        mem_axi_bready,
  input  logic        mem_axi_arvalid,
  output logic        mem_axi_arready,
  input  logic [31:0] mem_axi_araddr,
  input  logic [2:0]  mem_axi_arprot,
  output logic        mem_axi_rvalid,
  input  logic        mem_axi_rready,
  output logic [31:0] mem_axi_rdata,
  output logic        tests_passed,
  output logic        console_valid,
  output logic [7:0]  console_data
);

  localparam logic [31:0] RAM_LIMIT    = 32'h0002_0000;
  localparam logic [31:0] CONSOLE_ADDR = 32'h1000_0000;
  localparam logic [31:0] PASS_ADDR    = 32'h2000_0000;
  localparam logic [31:0] PASS_MAGIC   = 32'd123456789;
  localparam logic [31:0] BAD_DATA     = 32'hDEAD_BEEF;
  localparam logic [15:0] LFSR_SEED    = 16'hACE1;

  // 128 KiB of words; the name is kept so benches can preload it hierarchically
  logic [31:0] memory [0:32767];

  logic [15:0] lfsr;
  logic [4:0]  g;

  logic        aw_full;
  logic [31:0] aw_addr;
  logic        w_full;
  logic [31:0] w_data;
  logic [3:0]  w_strb;
  logic        ar_full;
  logic [31:0] ar_addr;

  logic aw_hs;
  logic w_hs;
  logic ar_hs;
  logic b_hs;
  logic r_hs;
  logic wr_commit;
  logic rd_commit;
  logic wr_in_ram;
  logic rd_in_ram;

  logic unused_prot;
  assign unused_prot = ^{mem_axi_awprot, mem_axi_arprot};

  // Stall gates: LFSR bits in stress mode, always open otherwise
  assign g = (AXI_TEST != 0) ? lfsr[4:0] : 5'b11111;

  assign mem_axi_awready = resetn & ~aw_full & g[1];
  assign mem_axi_wready  = resetn & ~w_full & g[2];
  assign mem_axi_arready = resetn & ~ar_full & ~mem_axi_rvalid & g[0];

  assign aw_hs = mem_axi_awvalid & mem_axi_awready;
  assign w_hs  = mem_axi_wvalid & mem_axi_wready;
  assign ar_hs = mem_axi_arvalid & mem_axi_arready;
  assign b_hs  = mem_axi_bvalid & mem_axi_bready;
  assign r_hs  = mem_axi_rvalid & mem_axi_rready;

  // A write commits once both halves are latched and the previous response is gone
  assign wr_commit = aw_full & w_full & ~mem_axi_bvalid & g[4];
  assign rd_commit = ar_full & g[3];

  assign wr_in_ram = aw_addr < RAM_LIMIT;
  assign rd_in_ram = ar_addr < RAM_LIMIT;

  // Byte-masked RAM update at write commit; contents survive reset
  always_ff @(posedge clk) begin
    if (resetn && wr_commit && wr_in_ram) begin
      for (int i = 0; i < 4; i++) begin
        if (w_strb[i]) begin
          memory[aw_addr[16:2]][8*i +: 8] <= w_data[8*i +: 8];
        end
      end
    end
  end

  // Handshake latches, responses, stall LFSR and device registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      lfsr           <= LFSR_SEED;
      aw_full        <= 1'b0;
      aw_addr        <= 32'h0;
      w_full         <= 1'b0;
      w_data         <= 32'h0;
      w_strb         <= 4'h0;
      ar_full        <= 1'b0;
      ar_addr        <= 32'h0;
      mem_axi_bvalid <= 1'b0;
      mem_axi_rvalid <= 1'b0;
      mem_axi_rdata  <= 32'h0;
      tests_passed   <= 1'b0;
      console_valid  <= 1'b0;
      console_data   <= 8'h0;
    end else begin
      lfsr          <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      console_valid <= 1'b0;

      if (aw_hs) begin
        aw_full <= 1'b1;
        aw_addr <= mem_axi_awaddr;
      end
      if (w_hs) begin
        w_full <= 1'b1;
        w_data <= mem_axi_wdata;
        w_strb <= mem_axi_wstrb;
      end

      if (wr_commit) begin
        aw_full        <= 1'b0;
        w_full         <= 1'b0;
        mem_axi_bvalid <= 1'b1;
        if (aw_addr == CONSOLE_ADDR) begin
          console_valid <= 1'b1;
          console_data  <= w_data[7:0];
        end
        if (aw_addr == PASS_ADDR && w_data == PASS_MAGIC) begin
          tests_passed <= 1'b1;
        end
      end else if (b_hs) begin
        mem_axi_bvalid <= 1'b0;
      end

      if (ar_hs) begin
        ar_full <= 1'b1;
        ar_addr <= mem_axi_araddr;
      end
      if (rd_commit) begin
        ar_full        <= 1'b0;
        mem_axi_rvalid <= 1'b1;
        mem_axi_rdata  <= rd_in_ram ? memory[ar_addr[16:2]] : BAD_DATA;
      end else if (r_hs) begin
        mem_axi_rvalid <= 1'b0;
      end
    end
  end

  // Simulation console output, unmapped-write report and optional transaction trace
  always_ff @(posedge clk) begin
    if (resetn && wr_commit) begin
      if (VERBOSE != 0) begin
        $display("WR %08x %08x %x", aw_addr, w_data, w_strb);
      end
      if (aw_addr == CONSOLE_ADDR) begin
        $write("%c", w_data[7:0]);
      end else if (!wr_in_ram && aw_addr != PASS_ADDR) begin
        $display("error: write to unmapped address %08x", aw_addr);
      end
    end
    if (resetn && rd_commit && VERBOSE != 0) begin
      $display("RD %08x %08x", ar_addr, rd_in_ram ? memory[ar_addr[16:2]] : BAD_DATA);
    end
  end

endmodule

// File: tb/tb_axi4_lite_sim_memory.sv
// tb/tb_axi4_lite_sim_memory.sv - checks directed timing on a fast instance and random traffic on a stalling instance
module tb_axi4_lite_sim_memory;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  // Index 0: AXI_TEST=0 instance, index 1: AXI_TEST=1 instance
  logic        awvalid [2];
  logic        awready [2];
  logic [31:0] awaddr  [2];
  logic        wvalid  [2];
  logic        wready  [2];
  logic [31:0] wdata   [2];
  logic [3:0]  wstrb   [2];
  logic        bvalid  [2];
  logic        bready  [2];
  logic        arvalid [2];
  logic        arready [2];
  logic [31:0] araddr  [2];
  logic        rvalid  [2];
  logic        rready  [2];
  logic [31:0] rdata   [2];
  logic        tp      [2];
  logic        cv      [2];
  logic [7:0]  cd      [2];

  axi4_lite_sim_memory #(.AXI_TEST(0), .VERBOSE(0)) dut0 (
    .clk(clk), .resetn(resetn),
    .mem_axi_awvalid(awvalid[0]), .mem_axi_awready(awready[0]), .mem_axi_awaddr(awaddr[0]), .mem_axi_awprot(3'b000),
    .mem_axi_wvalid(wvalid[0]), .mem_axi_wready(wready[0]), .mem_axi_wdata(wdata[0]), .mem_axi_wstrb(wstrb[0]),
    .mem_axi_bvalid(bvalid[0]), .mem_axi_bready(bready[0]),
    .mem_axi_arvalid(arvalid[0]), .mem_axi_arready(arready[0]), .mem_axi_araddr(araddr[0]), .mem_axi_arprot(3'b000),
    .mem_axi_rvalid(rvalid[0]), .mem_axi_rready(rready[0]), .mem_axi_rdata(rdata[0]),
    .tests_passed(tp[0]), .console_valid(cv[0]), .console_data(cd[0])
  );

  axi4_lite_sim_memory #(.AXI_TEST(1), .VERBOSE(0)) dut1 (
    .clk(clk), .resetn(resetn),
    .mem_axi_awvalid(awvalid[1]), .mem_axi_awready(awready[1]), .mem_axi_awaddr(awaddr[1]), .mem_axi_awprot(3'b000),
    .mem_axi_wvalid(wvalid[1]), .mem_axi_wready(wready[1]), .mem_axi_wdata(wdata[1]), .mem_axi_wstrb(wstrb[1]),
    .mem_axi_bvalid(bvalid[1]), .mem_axi_bready(bready[1]),
    .mem_axi_arvalid(arvalid[1]), .mem_axi_arready(arready[1]), .mem_axi_araddr(araddr[1]), .mem_axi_arprot(3'b000),
    .mem_axi_rvalid(rvalid[1]), .mem_axi_rready(rready[1]), .mem_axi_rdata(rdata[1]),
    .tests_passed(tp[1]), .console_valid(cv[1]), .console_data(cd[1])
  );

  int total = 0;
  int bad = 0;
  int cv_cnt = 0;
  logic [7:0] cv_last = 8'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%08h want=%08h", name, act, exp);
    end
  endtask

  // Console pulses seen on the fast instance
  always @(negedge clk) begin
    if (cv[0] === 1'b1) begin
      cv_cnt++;
      cv_last = cd[0];
    end
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Full write transaction; called and returns at a negedge
  task automatic do_write(input int d, input logic [31:0] a, input logic [31:0] dat, input logic [3:0] s);
    bit aw_done = 0, w_done = 0, b_done = 0;
    bit aw_hs, w_hs, b_hs, b_wait;
    awaddr[d] = a; wdata[d] = dat; wstrb[d] = s;
    awvalid[d] = 1'b1; wvalid[d] = 1'b1;
    for (int c = 0; c < 300 && !b_done; c++) begin
      bready[d] = (d == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      aw_hs  = awvalid[d] && awready[d];
      w_hs   = wvalid[d] && wready[d];
      b_hs   = bvalid[d] && bready[d];
      b_wait = bvalid[d] && !bready[d];
      cyc();
      if (aw_hs) begin aw_done = 1; awvalid[d] = 1'b0; end
      if (w_hs) begin w_done = 1; wvalid[d] = 1'b0; end
      if (b_hs) b_done = 1;
      if (b_wait) chk("bvalid_hold", bvalid[d], 1);
    end
    chk("write_complete", {29'b0, aw_done, w_done, b_done}, 7);
    awvalid[d] = 1'b0; wvalid[d] = 1'b0; bready[d] = 1'b0;
  endtask

  // Full read transaction; checks rvalid/rdata stability while rready is low
  task automatic do_read(input int d, input logic [31:0] a, output logic [31:0] dat);
    bit ar_done = 0, r_done = 0;
    bit ar_hs, r_hs, r_wait;
    logic [31:0] held;
    dat = 32'hx;
    araddr[d] = a; arvalid[d] = 1'b1;
    for (int c = 0; c < 300 && !r_done; c++) begin
      rready[d] = (d == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      ar_hs  = arvalid[d] && arready[d];
      r_hs   = rvalid[d] && rready[d];
      r_wait = rvalid[d] && !rready[d];
      held   = rdata[d];
      if (r_hs) dat = rdata[d];
      cyc();
      if (ar_hs) begin ar_done = 1; arvalid[d] = 1'b0; end
      if (r_hs) r_done = 1;
      if (r_wait) begin
        chk("rvalid_hold", rvalid[d], 1);
        chk("rdata_hold", rdata[d], held);
      end
    end
    chk("read_complete", {30'b0, ar_done, r_done}, 3);
    arvalid[d] = 1'b0; rready[d] = 1'b0;
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp;
  } vec_t;

  vec_t vec [10];
  logic [31:0] model [16];
  logic [31:0] got;

  initial begin
    vec[0] = '{0, 32'h0000_0020, 32'h0, 4'h0, 32'h00BB_00DD};
    vec[1] = '{0, 32'h0000_0028, 32'h0, 4'h0, 32'hCAFE_F00D};
    vec[2] = '{1, 32'h0000_0024, 32'hDEAD_C0DE, 4'hF, 32'h0};
    vec[3] = '{0, 32'h0000_0024, 32'h0, 4'h0, 32'hDEAD_C0DE};
    vec[4] = '{1, 32'h0000_0024, 32'h5566_7788, 4'b1010, 32'h0};
    vec[5] = '{0, 32'h0000_0024, 32'h0, 4'h0, 32'h55AD_77DE};
    vec[6] = '{0, 32'h0004_0000, 32'h0, 4'h0, 32'hDEAD_BEEF};
    vec[7] = '{0, 32'h0000_0010, 32'h0, 4'h0, 32'h1234_5678};
    vec[8] = '{1, 32'h0000_0024, 32'hFFFF_FFFF, 4'h0, 32'h0};
    vec[9] = '{0, 32'h0000_0024, 32'h0, 4'h0, 32'h55AD_77DE};

    for (int d = 0; d < 2; d++) begin
      awvalid[d] = 0; awaddr[d] = 0; wvalid[d] = 0; wdata[d] = 0; wstrb[d] = 0;
      bready[d] = 0; arvalid[d] = 0; araddr[d] = 0; rready[d] = 0;
    end

    dut0.memory[4]  = 32'h1234_5678;
    dut0.memory[8]  = 32'h0;
    dut0.memory[11] = 32'h1111_1111;
    dut0.memory[12] = 32'h0;
    for (int i = 0; i < 16; i++) begin
      model[i] = $urandom;
      dut1.memory[64 + i] = model[i];
    end

    repeat (3) @(negedge clk);
    chk("awready_in_reset", awready[0], 0);
    chk("arready_in_reset", arready[0], 0);
    resetn = 1'b1;
    @(negedge clk);
    chk("rst_awready", awready[0], 1);
    chk("rst_wready", wready[0], 1);
    chk("rst_arready", arready[0], 1);
    chk("rst_bvalid", bvalid[0], 0);
    chk("rst_rvalid", rvalid[0], 0);
    chk("rst_rdata", rdata[0], 0);
    chk("rst_tp", {tp[1], tp[0]}, 0);
    chk("rst_cv", {cv[1], cv[0]}, 0);

    // Read latency: rvalid one edge after the AR handshake edge
    araddr[0] = 32'h10; arvalid[0] = 1'b1;
    chk("lat_arready", arready[0], 1);
    cyc();
    arvalid[0] = 1'b0;
    chk("lat_rvalid_early", rvalid[0], 0);
    chk("lat_arready_busy", arready[0], 0);
    cyc();
    chk("lat_rvalid", rvalid[0], 1);
    chk("lat_rdata", rdata[0], 32'h1234_5678);
    rready[0] = 1'b1; cyc(); rready[0] = 1'b0;
    chk("lat_rvalid_clear", rvalid[0], 0);

    // Masked write with bvalid held until bready
    awaddr[0] = 32'h20; wdata[0] = 32'hAABB_CCDD; wstrb[0] = 4'b0101;
    awvalid[0] = 1'b1; wvalid[0] = 1'b1;
    cyc();
    awvalid[0] = 1'b0; wvalid[0] = 1'b0;
    chk("wr_bvalid_early", bvalid[0], 0);
    cyc();
    chk("wr_bvalid", bvalid[0], 1);
    repeat (3) begin
      cyc();
      chk("wr_bvalid_held", bvalid[0], 1);
    end
    bready[0] = 1'b1; cyc(); bready[0] = 1'b0;
    chk("wr_bvalid_clear", bvalid[0], 0);

    // W three cycles ahead of AW: single commit one edge after AW handshake
    wdata[0] = 32'hCAFE_F00D; wstrb[0] = 4'hF; wvalid[0] = 1'b1;
    cyc();
    wvalid[0] = 1'b0;
    chk("wfirst_wready_full", wready[0], 0);
    repeat (3) begin
      chk("wfirst_no_b", bvalid[0], 0);
      cyc();
    end
    awaddr[0] = 32'h28; awvalid[0] = 1'b1;
    cyc();
    awvalid[0] = 1'b0;
    chk("wfirst_b_early", bvalid[0], 0);
    cyc();
    chk("wfirst_b", bvalid[0], 1);
    bready[0] = 1'b1; cyc(); bready[0] = 1'b0;

    // Same-word read and write committing on the same edge returns old data
    awaddr[0] = 32'h2C; wdata[0] = 32'h2222_2222; wstrb[0] = 4'hF; araddr[0] = 32'h2C;
    awvalid[0] = 1'b1; wvalid[0] = 1'b1; arvalid[0] = 1'b1;
    cyc();
    awvalid[0] = 1'b0; wvalid[0] = 1'b0; arvalid[0] = 1'b0;
    cyc();
    chk("same_rvalid", rvalid[0], 1);
    chk("same_bvalid", bvalid[0], 1);
    chk("same_old_data", rdata[0], 32'h1111_1111);
    rready[0] = 1'b1; bready[0] = 1'b1; cyc(); rready[0] = 1'b0; bready[0] = 1'b0;
    do_read(0, 32'h2C, got);
    chk("same_new_data", got, 32'h2222_2222);

    // Directed vector table on the fast instance
    for (int i = 0; i < 10; i++) begin
      if (vec[i].wr) do_write(0, vec[i].addr, vec[i].data, vec[i].strb);
      else begin
        do_read(0, vec[i].addr, got);
        chk($sformatf("vec%0d_rdata", i), got, vec[i].exp);
      end
    end

    // Devices
    do_write(0, 32'h2000_0000, 32'd5, 4'hF);
    chk("tp_wrong_value", tp[0], 0);
    do_write(0, 32'h1000_0000, 32'h41, 4'hF);
    $display("");
    chk("console_pulses", cv_cnt, 1);
    chk("console_data", cv_last, 32'h41);
    chk("console_low", cv[0], 0);
    do_write(0, 32'h2000_0000, 32'd123456789, 4'hF);
    chk("tp_set", tp[0], 1);
    do_write(0, 32'h2000_0000, 32'd5, 4'hF);
    chk("tp_sticky", tp[0], 1);

    // Reset between handshake and commit: the write is dropped
    awaddr[0] = 32'h30; wdata[0] = 32'hFFFF_FFFF; wstrb[0] = 4'hF;
    awvalid[0] = 1'b1; wvalid[0] = 1'b1;
    cyc();
    awvalid[0] = 1'b0; wvalid[0] = 1'b0;
    resetn = 1'b0;
    cyc();
    chk("rst_mid_bvalid", bvalid[0], 0);
    resetn = 1'b1;
    cyc();
    chk("rst_mid_tp", tp[0], 0);
    chk("rst_mid_bvalid2", bvalid[0], 0);
    cyc();
    chk("rst_mid_bvalid3", bvalid[0], 0);
    do_read(0, 32'h30, got);
    chk("rst_mid_no_write", got, 0);

    // Random traffic on the stalling instance against a word-array model
    for (int n = 0; n < 1000; n++) begin
      int idx;
      logic [31:0] a, dat, mask;
      logic [3:0] s;
      idx = $urandom_range(0, 15);
      a = 32'h100 + 32'(idx) * 4;
      if ($urandom_range(0, 1) == 1) begin
        dat = $urandom;
        s = 4'($urandom_range(0, 15));
        mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        do_write(1, a, dat, s);
        model[idx] = (model[idx] & ~mask) | (dat & mask);
      end else begin
        do_read(1, a, got);
        chk($sformatf("rand%0d_rdata", n), got, model[idx]);
      end
    end
    do_read(1, 32'h0004_0000, got);
    chk("rand_oob", got, 32'hDEAD_BEEF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
